// File: rtl/float_div_ctrl.sv
// float_div_ctrl: sequencer wrapped around the free-running iterative divider.
// Takes operand pairs on a valid/ready request channel, holds them on the
// divider inputs for a fixed window, then presents the captured quotient and
// flags on a valid/ready response channel. Operands whose result is known
// without dividing (Inf/NaN exponent, zero dividend) skip the divider.
module float_div_ctrl #(
  parameter int WAIT_CYCLES = 28,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_s,
  input  logic        div_ovf,
  input  logic        div_err,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_s,
  output logic        rsp_ovf,
  output logic        rsp_err,
  output logic        rsp_fast,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_div_a;
  logic [31:0]        r_div_b;
  logic [31:0]        r_rsp_s;
  logic               r_rsp_ovf;
  logic               r_rsp_err;
  logic               r_rsp_fast;

  logic               w_a_exp_ff;
  logic               w_b_exp_ff;
  logic               w_a_zero;
  logic               w_b_zero;
  logic               w_fast;
  logic               w_cnt_done;

  // Operand classification for the fast path; only meaningful in IDLE.
  assign w_a_exp_ff = (req_a[30:23] == 8'hFF);
  assign w_b_exp_ff = (req_b[30:23] == 8'hFF);
  assign w_a_zero   = (req_a == 32'h0);
  assign w_b_zero   = (req_b == 32'h0);
  assign w_fast     = w_a_exp_ff | w_b_exp_ff | w_a_zero;
  assign w_cnt_done = (r_cnt == CNT_W'(WAIT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a request is accepted in IDLE only, never on the
  // response handshake edge.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_state_next = w_fast ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_cnt_done) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: operand latch, wait counter and result capture. The divider
  // inputs only move on an accept, so the divider never restarts spuriously.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_div_a    <= 32'h0;
      r_div_b    <= 32'h0;
      r_rsp_s    <= 32'h0;
      r_rsp_ovf  <= 1'b0;
      r_rsp_err  <= 1'b0;
      r_rsp_fast <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_div_a <= req_a;
            r_div_b <= req_b;
            if (w_a_exp_ff || w_b_exp_ff) begin
              r_rsp_s    <= 32'h7F80_0000;
              r_rsp_ovf  <= 1'b1;
              r_rsp_err  <= w_b_zero;
              r_rsp_fast <= 1'b1;
            end else if (w_a_zero) begin
              r_rsp_s    <= 32'h0;
              r_rsp_ovf  <= 1'b0;
              r_rsp_err  <= w_b_zero;
              r_rsp_fast <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          // Identical operands leave the divider idle with its previous,
          // still-valid result, so the same wait window is safe either way.
          r_cnt <= '0;
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_cnt_done) begin
            r_rsp_s    <= div_s;
            r_rsp_ovf  <= div_ovf;
            r_rsp_err  <= div_err;
            r_rsp_fast <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign busy      = (r_state != ST_IDLE);
  assign div_a     = r_div_a;
  assign div_b     = r_div_b;
  assign rsp_s     = r_rsp_s;
  assign rsp_ovf   = r_rsp_ovf;
  assign rsp_err   = r_rsp_err;
  assign rsp_fast  = r_rsp_fast;

endmodule

// File: tb/tb_float_div_ctrl.sv
// Bench for float_div_ctrl: behavioural divider stand-in plus a reference
// model of the expected response and latency for each operand pair.
module tb_float_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] div_s;
  logic        div_ovf;
  logic        div_err;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_s;
  logic        rsp_ovf;
  logic        rsp_err;
  logic        rsp_fast;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  bit tb_expect_rsp = 1'b0;
  int div_chg = 0;
  logic [63:0] prev_div = 64'h0;

  always #5 clk = ~clk;

  float_div_ctrl #(.WAIT_CYCLES(28), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .div_a(div_a), .div_b(div_b),
    .div_s(div_s), .div_ovf(div_ovf), .div_err(div_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_s(rsp_s), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
    .rsp_fast(rsp_fast), .busy(busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Settled divider answer {S, ovf, err}: known quotients for directed
  // vectors, an arbitrary deterministic mapping for random operands.
  function automatic logic [33:0] div_true(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C0_0000 && b == 32'h4000_0000) return {32'h4040_0000, 1'b0, 1'b0};
    if (a == 32'h3F80_0000 && b == 32'h4040_0000) return {32'h3EAA_AAAA, 1'b0, 1'b0};
    if (a == 32'h7F00_0000 && b == 32'h0080_0000) return {32'h7F80_0000, 1'b1, 1'b0};
    return {a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_5A5A, ^a[30:23], (b == 32'h0)};
  endfunction

  // Expected response {fast, S, ovf, err} from the operand rules.
  function automatic logic [34:0] expect_rsp(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {1'b1, 32'h7F80_0000, 1'b1, (b == 32'h0)};
    if (a == 32'h0) return {1'b1, 32'h0, 1'b0, (b == 32'h0)};
    return {1'b0, div_true(a, b)};
  endfunction

  // Divider stand-in: restarts when its inputs change, shows garbage for a
  // random 1..25 cycles, then holds the settled result.
  logic [31:0] m_a = 32'h0;
  logic [31:0] m_b = 32'h0;
  int          m_left = 0;
  logic [33:0] m_true;
  always @(posedge clk) begin
    if (div_a !== m_a || div_b !== m_b) begin
      m_a    <= div_a;
      m_b    <= div_b;
      m_left <= $urandom_range(1, 25);
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
    end
  end
  always_comb begin
    m_true = div_true(m_a, m_b);
    if (m_left == 0) {div_s, div_ovf, div_err} = m_true;
    else             {div_s, div_ovf, div_err} = {32'hDEAD_0000 | 32'(m_left), 1'b1, 1'b0};
  end

  // Response monitor: no response may appear unless one is outstanding;
  // also counts changes on the divider operand bus.
  always @(negedge clk) begin
    if (rst === 1'b0 && rsp_valid === 1'b1) check_val("no_spurious_rsp", 32'(tb_expect_rsp), 32'd1);
    if ({div_a, div_b} !== prev_div) begin
      div_chg++;
      prev_div = {div_a, div_b};
    end
  end

  // One transaction, called at a negedge. hold>0 keeps rsp_ready low for
  // that many cycles while another request is pending.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [34:0] e;
    int          cyc;
    e = expect_rsp(a, b);
    req_a = a; req_b = b; req_valid = 1'b1;
    cyc = 0;
    while (req_ready !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_val("req_ready", req_ready, 32'd1);
    tb_expect_rsp = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    check_val("div_a_latch", div_a, a);
    check_val("div_b_latch", div_b, b);
    while (rsp_valid !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_val("latency", 32'(cyc), e[34] ? 32'd1 : 32'd30);
    check_val("rsp_s", rsp_s, e[33:2]);
    check_val("rsp_ovf", rsp_ovf, e[1]);
    check_val("rsp_err", rsp_err, e[0]);
    check_val("rsp_fast", rsp_fast, e[34]);
    if (hold > 0) begin
      req_valid = 1'b1; req_a = ~a; req_b = b;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check_val("hold_req_ready", req_ready, 32'd0);
        check_val("hold_rsp_valid", rsp_valid, 32'd1);
        check_val("hold_rsp_s", rsp_s, e[33:2]);
        check_val("hold_rsp_flags", {rsp_fast, rsp_ovf, rsp_err}, {e[34], e[1], e[0]});
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    tb_expect_rsp = 1'b0;
    check_val("rsp_valid_drop", rsp_valid, 32'd0);
    check_val("idle_busy", busy, 32'd0);
    check_val("idle_req_ready", req_ready, 32'd1);
    $display("txn a=%h b=%h -> s=%h ovf=%0d err=%0d fast=%0d lat=%0d hold=%0d",
             a, b, rsp_s, rsp_ovf, rsp_err, rsp_fast, cyc, hold);
  endtask

  initial begin
    int          c0;
    int          sel;
    int          hold;
    logic [31:0] a;
    logic [31:0] b;
    rst = 1'b1; req_valid = 1'b0; req_a = 32'h0; req_b = 32'h0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_req_ready", req_ready, 32'd1);
    check_val("rst_rsp_valid", rsp_valid, 32'd0);
    check_val("rst_busy", busy, 32'd0);
    check_val("rst_rsp_s", rsp_s, 32'h0);
    check_val("rst_rsp_flags", {rsp_fast, rsp_ovf, rsp_err}, 32'd0);
    check_val("rst_div_a", div_a, 32'h0);
    check_val("rst_div_b", div_b, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    run_txn(32'h40C0_0000, 32'h4000_0000, 0);
    run_txn(32'h3F80_0000, 32'h4040_0000, 0);
    c0 = div_chg;
    run_txn(32'h3F80_0000, 32'h4040_0000, 0);
    check_val("no_div_restart", 32'(div_chg), 32'(c0));
    run_txn(32'h7F80_0000, 32'h3F80_0000, 0);
    run_txn(32'h0000_0000, 32'h0000_0000, 0);
    run_txn(32'h40C0_0000, 32'h4000_0000, 10);

    // Abort a slow transaction with reset at wait count 12.
    req_a = 32'h4120_0000; req_b = 32'h4040_0000; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (13) @(negedge clk);
    check_val("pre_rst_busy", busy, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_rsp_valid", rsp_valid, 32'd0);
    check_val("abort_req_ready", req_ready, 32'd1);
    check_val("abort_busy", busy, 32'd0);
    repeat (40) @(negedge clk);
    check_val("abort_no_rsp", rsp_valid, 32'd0);
    $display("txn reset-abort a=41200000 b=40400000 -> discarded");

    run_txn(32'h7F00_0000, 32'h0080_0000, 0);
    run_txn(32'h3F80_0000, 32'h0000_0000, 0);

    for (int t = 0; t < 20; t++) begin
      a = $urandom();
      b = $urandom();
      a[30:23] = 8'($urandom_range(1, 254));
      b[30:23] = 8'($urandom_range(1, 254));
      sel = $urandom_range(0, 9);
      case (sel)
        0: a[30:23] = 8'hFF;
        1: b[30:23] = 8'hFF;
        2: a = 32'h0;
        3: b = 32'h0;
        default: ;
      endcase
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      run_txn(a, b, hold);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
